calc_entry_fsm: RTL and testbench
=================================

Name: calc_entry_fsm

Overview:
Main calculator control FSM that sits between keyboardCtrl (upstream) and the ALU / display path (downstream).
- Consumes one-cycle key strobes and assembles two BCD operands plus an operator.
- Sequences the ALU, captures its result and selects the 16-bit BCD word driven to the display multiplexer.
- Supports chained operations and repeat-equals.

Parameters:
ALU_LAT, 1, clock cycles from stable ALUNum1/ALUNum2/ALUOp to valid ALURes (1..15)
NUM_DIGITS, 4, maximum BCD digits per operand (1..4)

Ports:
CLK  input  1  system clock (SB_LFOSC domain)
RESET  input  1  asynchronous, active-high reset
BCDKey  input  4  key code: 0-9 digit, A-D operator, E equals, F clear
KeyRead  input  1  one-cycle strobe; BCDKey valid in the same cycle
ALURes  input  16  ALU result, 4 BCD digits
ALUNum1  output  16  operand 1, 4 BCD digits
ALUNum2  output  16  operand 2, 4 BCD digits
ALUOp  output  4  operator key code (A-D) passed through unchanged
Display  output  16  BCD word to the display path
Busy  output  1  high while waiting on ALU; key strobes are dropped

Behaviour:
- Reset (async, overrides KeyRead): state ENTER1; ALUNum1=0, ALUNum2=0, ALUOp=4'hA, Display=0, Busy=0, digit counts=0, chain flag=0.
- Registered outputs; every key is acted on in the cycle after its KeyRead strobe.
- Digit entry into operand X: X <= {X[11:0], key}, count++.
  - Ignored when count==NUM_DIGITS.
  - Key 0 while X==0 leaves X=0 and count unchanged.
- States:
  - ENTER1: Display=ALUNum1.
    - Digit: enter into num1.
    - Operator: latch ALUOp, clear num2/count2, go ENTER2.
    - E: ignored.
  - ENTER2: Display=ALUNum1 while count2==0, else ALUNum2.
    - Digit: enter into num2.
    - Operator with count2==0: replace ALUOp, stay.
    - Operator with count2>0: store it as pending, set chain flag, go WAIT.
    - E with count2>0: go WAIT.
    - E with count2==0: ignored.
  - WAIT: Busy=1; counter counts ALU_LAT+1 cycles.
    - On expiry: ALUNum1<=ALURes, Display<=ALURes, count1 <= number of significant digits of ALURes, Busy=0.
    - If chain flag set: ALUOp<=pending, clear num2/count2 and chain flag, go ENTER2.
    - Otherwise go SHOW.
  - SHOW: Display=ALUNum1 (result).
    - Digit: num1 <= key, count1 = (key!=0), go ENTER1.
    - Operator: latch ALUOp, clear num2/count2, go ENTER2.
    - E: repeat last op with num1=result and unchanged num2, go WAIT.
- F (clear), in any non-WAIT state: same values as reset.
- KeyRead in WAIT, including F: dropped, no state change.
- Result >9999 or ALU error: out of scope; ALURes is captured as-is.
- ALUNum1/ALUNum2/ALUOp are held stable for the whole of WAIT.

Optional Feature:
CALC_BACKSPACE_EN
- Defined: key D is backspace.
  - Active operand <= {4'h0, X[15:4]}, count-- (no change at count 0).
  - In SHOW: acts on the result, then go ENTER1.
  - Operators are A-C only.
- Undefined: D is the fourth operator; no backspace.

Test Plan:
- Reset, then keys 1,2,+A,3,E with ALURes stub = num1+num2 (BCD) -> Display 0x0012, then 0x0003, then 0x0015 after ALU_LAT+1 cycles; Busy high for exactly ALU_LAT+1 cycles.
- Keys 1,2,3,4,5 -> ALUNum1=0x1234, fifth digit ignored; keys 0,0,7 from reset -> ALUNum1=0x0007.
- Keys 5,A,B,2,E -> ALUOp=B; operator replaced before any num2 digit.
- Chain: 2,A,3,A,4,E with adder stub -> intermediate Display 0x0005, ALUOp=A, final 0x0009; then E again -> 0x0013 (repeat +4).
- KeyRead of digit 9 during WAIT -> ignored, ALUNum1/ALUNum2 unchanged; RESET asserted mid-WAIT -> all outputs 0, ALUOp=A, Busy=0 immediately.
- With CALC_BACKSPACE_EN: 1,2,3,D -> ALUNum1=0x0012; D on empty operand -> stays 0. Without it: D latches ALUOp=4'hD.

Source files
------------

// File: rtl/calc_entry_fsm.sv
// Calculator entry/control FSM: assembles BCD operands and operator from key strobes and
// sequences the ALU. Define CALC_BACKSPACE_EN to turn key D into backspace.
module calc_entry_fsm #(
  parameter int unsigned ALU_LAT    = 1,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  BCDKey,
  input  logic        KeyRead,
  input  logic [15:0] ALURes,
  output logic [15:0] ALUNum1,
  output logic [15:0] ALUNum2,
  output logic [3:0]  ALUOp,
  output logic [15:0] Display,
  output logic        Busy
);

  typedef enum logic [1:0] {StEnter1, StEnter2, StWait, StShow} state_e;

  localparam logic [2:0] MaxCnt   = 3'(NUM_DIGITS);
  localparam logic [4:0] WaitLast = 5'(ALU_LAT);

  state_e      state_q, state_d;
  logic [15:0] num1_q, num1_d, num2_q, num2_d, disp_q, disp_d;
  logic [3:0]  op_q, op_d, pend_q, pend_d;
  logic [2:0]  cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [4:0]  wcnt_q, wcnt_d;
  logic        chain_q, chain_d, busy_q, busy_d;
  logic        key_digit, key_op, key_eq, key_clr, key_bs;
  logic [2:0]  res_cnt;

  function automatic logic digit_ok(logic [15:0] num, logic [2:0] cnt, logic [3:0] key);
    return (cnt < MaxCnt) && !((key == 4'h0) && (num == 16'h0000));
  endfunction

  always_comb begin
    key_digit = (BCDKey <= 4'd9);
    key_eq    = (BCDKey == 4'hE);
    key_clr   = (BCDKey == 4'hF);
`ifdef CALC_BACKSPACE_EN
    key_bs    = (BCDKey == 4'hD);
    key_op    = (BCDKey >= 4'hA) && (BCDKey <= 4'hC);
`else
    key_bs    = 1'b0;
    key_op    = (BCDKey >= 4'hA) && (BCDKey <= 4'hD);
`endif
  end

  // Significant digits of the result, so further entry continues from the right count.
  always_comb begin
    res_cnt = 3'd0;
    if (ALURes[15:12] != 4'h0)     res_cnt = 3'd4;
    else if (ALURes[11:8] != 4'h0) res_cnt = 3'd3;
    else if (ALURes[7:4] != 4'h0)  res_cnt = 3'd2;
    else if (ALURes[3:0] != 4'h0)  res_cnt = 3'd1;
  end

  always_comb begin
    state_d = state_q;
    num1_d  = num1_q;
    num2_d  = num2_q;
    op_d    = op_q;
    pend_d  = pend_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    wcnt_d  = wcnt_q;
    chain_d = chain_q;
    disp_d  = disp_q;

    unique case (state_q)
      StEnter1: begin
        if (KeyRead) begin
          if (key_digit) begin
            if (digit_ok(num1_q, cnt1_q, BCDKey)) begin
              num1_d = {num1_q[11:0], BCDKey};
              cnt1_d = cnt1_q + 3'd1;
            end
          end else if (key_op) begin
            op_d    = BCDKey;
            num2_d  = 16'h0000;
            cnt2_d  = 3'd0;
            state_d = StEnter2;
          end else if (key_bs && (cnt1_q != 3'd0)) begin
            num1_d = {4'h0, num1_q[15:4]};
            cnt1_d = cnt1_q - 3'd1;
          end
        end
      end
      StEnter2: begin
        if (KeyRead) begin
          if (key_digit) begin
            if (digit_ok(num2_q, cnt2_q, BCDKey)) begin
              num2_d = {num2_q[11:0], BCDKey};
              cnt2_d = cnt2_q + 3'd1;
            end
          end else if (key_op) begin
            if (cnt2_q == 3'd0) begin
              op_d = BCDKey;
            end else begin
              pend_d  = BCDKey;
              chain_d = 1'b1;
              wcnt_d  = 5'd0;
              state_d = StWait;
            end
          end else if (key_eq) begin
            if (cnt2_q != 3'd0) begin
              wcnt_d  = 5'd0;
              state_d = StWait;
            end
          end else if (key_bs && (cnt2_q != 3'd0)) begin
            num2_d = {4'h0, num2_q[15:4]};
            cnt2_d = cnt2_q - 3'd1;
          end
        end
      end
      StWait: begin
        if (wcnt_q == WaitLast) begin
          num1_d = ALURes;
          cnt1_d = res_cnt;
          if (chain_q) begin
            op_d    = pend_q;
            num2_d  = 16'h0000;
            cnt2_d  = 3'd0;
            chain_d = 1'b0;
            state_d = StEnter2;
          end else begin
            state_d = StShow;
          end
        end else begin
          wcnt_d = wcnt_q + 5'd1;
        end
      end
      StShow: begin
        if (KeyRead) begin
          if (key_digit) begin
            num1_d  = {12'h000, BCDKey};
            cnt1_d  = {2'b00, (BCDKey != 4'h0)};
            state_d = StEnter1;
          end else if (key_op) begin
            op_d    = BCDKey;
            num2_d  = 16'h0000;
            cnt2_d  = 3'd0;
            state_d = StEnter2;
          end else if (key_eq) begin
            wcnt_d  = 5'd0;
            state_d = StWait;
          end else if (key_bs) begin
            if (cnt1_q != 3'd0) begin
              num1_d = {4'h0, num1_q[15:4]};
              cnt1_d = cnt1_q - 3'd1;
            end
            state_d = StEnter1;
          end
        end
      end
      default: state_d = StEnter1;
    endcase

    // Clear is honoured everywhere except while the ALU is in flight.
    if (KeyRead && key_clr && (state_q != StWait)) begin
      state_d = StEnter1;
      num1_d  = 16'h0000;
      num2_d  = 16'h0000;
      op_d    = 4'hA;
      pend_d  = 4'hA;
      cnt1_d  = 3'd0;
      cnt2_d  = 3'd0;
      wcnt_d  = 5'd0;
      chain_d = 1'b0;
    end

    case (state_d)
      StEnter2: disp_d = (cnt2_d == 3'd0) ? num1_d : num2_d;
      StWait:   disp_d = disp_q;
      default:  disp_d = num1_d;
    endcase
    busy_d = (state_d == StWait);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StEnter1;
      num1_q  <= 16'h0000;
      num2_q  <= 16'h0000;
      op_q    <= 4'hA;
      pend_q  <= 4'hA;
      cnt1_q  <= 3'd0;
      cnt2_q  <= 3'd0;
      wcnt_q  <= 5'd0;
      chain_q <= 1'b0;
      disp_q  <= 16'h0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      op_q    <= op_d;
      pend_q  <= pend_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      wcnt_q  <= wcnt_d;
      chain_q <= chain_d;
      disp_q  <= disp_d;
      busy_q  <= busy_d;
    end
  end

  assign ALUNum1 = num1_q;
  assign ALUNum2 = num2_q;
  assign ALUOp   = op_q;
  assign Display = disp_q;
  assign Busy    = busy_q;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Bench for calc_entry_fsm: directed scenarios plus random key streams against a decimal
// calculator model; the ALU stub is a delayed BCD add/sub/mul/diff.
module tb_calc_entry_fsm;

  localparam int unsigned ALU_LAT    = 1;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int MEnter1 = 0, MEnter2 = 1, MWait = 2, MShow = 3;
`ifdef CALC_BACKSPACE_EN
  localparam bit BS = 1'b1;
`else
  localparam bit BS = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  BCDKey;
  logic        KeyRead;
  logic [15:0] ALURes;
  logic [15:0] ALUNum1, ALUNum2, Display;
  logic [3:0]  ALUOp;
  logic        Busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: operands kept as plain decimal integers.
  int         m_st, m_n1, m_n2, m_c1, m_c2, m_disp;
  logic [3:0] m_op, m_pend;
  bit         m_chain;

  always #5 CLK = ~CLK;

  calc_entry_fsm #(.ALU_LAT(ALU_LAT), .NUM_DIGITS(NUM_DIGITS)) dut (
    .CLK(CLK), .RESET(RESET), .BCDKey(BCDKey), .KeyRead(KeyRead), .ALURes(ALURes),
    .ALUNum1(ALUNum1), .ALUNum2(ALUNum2), .ALUOp(ALUOp), .Display(Display), .Busy(Busy)
  );

  function automatic int bcd2int(logic [15:0] b);
    return 1000 * int'(b[15:12]) + 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(int v);
    logic [15:0] b;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      b[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  function automatic int alu_model(int a, int b, logic [3:0] op);
    case (op)
      4'hA:    return (a + b) % 10000;
      4'hB:    return (a - b + 10000) % 10000;
      4'hC:    return (a * b) % 10000;
      default: return (a > b) ? a - b : b - a;
    endcase
  endfunction

  function automatic int ndigits(int v);
    if (v == 0) return 0;
    if (v < 10) return 1;
    if (v < 100) return 2;
    if (v < 1000) return 3;
    return 4;
  endfunction

  // ALU stub: ALU_LAT register stages after the operands.
  logic [15:0] alu_pipe [ALU_LAT];
  always @(posedge CLK) begin
    alu_pipe[0] <= int2bcd(alu_model(bcd2int(ALUNum1), bcd2int(ALUNum2), ALUOp));
    for (int i = 1; i < int'(ALU_LAT); i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign ALURes = alu_pipe[ALU_LAT-1];

  task automatic model_reset();
    m_st = MEnter1; m_n1 = 0; m_n2 = 0; m_c1 = 0; m_c2 = 0; m_disp = 0;
    m_op = 4'hA; m_pend = 4'hA; m_chain = 1'b0;
  endtask

  task automatic enter_digit(inout int n, inout int c, input int k);
    if (c >= int'(NUM_DIGITS)) return;
    if (k == 0 && n == 0) return;
    n = n * 10 + k;
    c = c + 1;
  endtask

  task automatic back(inout int n, inout int c);
    if (c == 0) return;
    n = n / 10;
    c = c - 1;
  endtask

  task automatic model_key(input logic [3:0] k);
    bit is_dig, is_bs, is_op;
    is_dig = (k <= 4'd9);
    is_bs  = BS && (k == 4'hD);
    is_op  = (k >= 4'hA) && (k <= 4'hD) && !is_bs;
    if (m_st == MWait) return;
    if (k == 4'hF) begin
      model_reset();
      return;
    end
    case (m_st)
      MEnter1: begin
        if (is_dig) enter_digit(m_n1, m_c1, int'(k));
        else if (is_op) begin m_op = k; m_n2 = 0; m_c2 = 0; m_st = MEnter2; end
        else if (is_bs) back(m_n1, m_c1);
      end
      MEnter2: begin
        if (is_dig) enter_digit(m_n2, m_c2, int'(k));
        else if (is_op) begin
          if (m_c2 == 0) m_op = k;
          else begin m_pend = k; m_chain = 1'b1; m_st = MWait; end
        end else if (k == 4'hE) begin
          if (m_c2 > 0) m_st = MWait;
        end else if (is_bs) back(m_n2, m_c2);
      end
      MShow: begin
        if (is_dig) begin m_n1 = int'(k); m_c1 = (k != 4'h0) ? 1 : 0; m_st = MEnter1; end
        else if (is_op) begin m_op = k; m_n2 = 0; m_c2 = 0; m_st = MEnter2; end
        else if (k == 4'hE) m_st = MWait;
        else if (is_bs) begin back(m_n1, m_c1); m_st = MEnter1; end
      end
      default: ;
    endcase
    if (m_st != MWait) m_disp = (m_st == MEnter2 && m_c2 != 0) ? m_n2 : m_n1;
  endtask

  task automatic model_finish();
    int r;
    r = alu_model(m_n1, m_n2, m_op);
    m_n1 = r; m_c1 = ndigits(r); m_disp = r;
    if (m_chain) begin
      m_op = m_pend; m_n2 = 0; m_c2 = 0; m_chain = 1'b0; m_st = MEnter2;
    end else begin
      m_st = MShow;
    end
  endtask

  // Strobe one key; if it starts an ALU run, count Busy cycles (bounded) and return them,
  // otherwise return -1. Optionally strobes a random key in the first WAIT cycle.
  task automatic press(input logic [3:0] k, input bit inject, output int busy_cycles);
    busy_cycles = -1;
    @(negedge CLK); KeyRead = 1'b1; BCDKey = k;
    @(negedge CLK); KeyRead = 1'b0;
    model_key(k);
    if (m_st == MWait) begin
      busy_cycles = 0;
      if (inject) begin KeyRead = 1'b1; BCDKey = 4'($urandom_range(0, 15)); end
      for (int i = 0; i < 40 && Busy === 1'b1; i++) begin
        busy_cycles++;
        @(negedge CLK); KeyRead = 1'b0;
      end
      KeyRead = 1'b0;
      model_finish();
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; KeyRead = 1'b1; BCDKey = 4'h5;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({Display, ALUNum1, ALUNum2, ALUOp, Busy} !== {48'h0, 4'hA, 1'b0})
      $display("FAIL reset_state: got %h %h %h %h %b", Display, ALUNum1, ALUNum2, ALUOp, Busy);
    else n_pass++;
    KeyRead = 1'b0; RESET = 1'b0;
    model_reset();
    @(negedge CLK);
    n_checks++;
    if ({Display, ALUNum1, ALUOp} !== {32'h0, 4'hA})
      $display("FAIL reset_idle: got %h %h %h", Display, ALUNum1, ALUOp);
    else n_pass++;
  endtask

  task automatic test_basic();
    int bc;
    press(4'hF, 0, bc); press(4'h1, 0, bc); press(4'h2, 0, bc);
    n_checks++;
    if (Display !== 16'h0012) $display("FAIL basic_num1: got %h want 0012", Display);
    else n_pass++;
    press(4'hA, 0, bc); press(4'h3, 0, bc);
    n_checks++;
    if (Display !== 16'h0003) $display("FAIL basic_num2: got %h want 0003", Display);
    else n_pass++;
    press(4'hE, 0, bc);
    n_checks++;
    if (bc !== int'(ALU_LAT + 1)) $display("FAIL basic_busy_len: got %0d want %0d", bc, ALU_LAT + 1);
    else n_pass++;
    n_checks++;
    if ({Display, ALUNum1} !== {16'h0015, 16'h0015})
      $display("FAIL basic_result: got %h/%h want 0015/0015", Display, ALUNum1);
    else n_pass++;
  endtask

  task automatic test_digit_limit();
    int bc;
    press(4'hF, 0, bc);
    for (int i = 1; i <= 5; i++) press(4'(i), 0, bc);
    n_checks++;
    if (ALUNum1 !== 16'h1234) $display("FAIL digit_limit: got %h want 1234", ALUNum1);
    else n_pass++;
    press(4'hF, 0, bc); press(4'h0, 0, bc); press(4'h0, 0, bc); press(4'h7, 0, bc);
    n_checks++;
    if ({ALUNum1, Display} !== {16'h0007, 16'h0007})
      $display("FAIL leading_zero: got %h/%h want 0007/0007", ALUNum1, Display);
    else n_pass++;
  endtask

  task automatic test_op_replace();
    int bc;
    press(4'hF, 0, bc); press(4'h5, 0, bc); press(4'hA, 0, bc); press(4'hB, 0, bc);
    n_checks++;
    if (ALUOp !== 4'hB) $display("FAIL op_replace: got %h want B", ALUOp);
    else n_pass++;
    press(4'h2, 0, bc); press(4'hE, 0, bc);
    n_checks++;
    if ({ALUOp, Display} !== {4'hB, 16'h0003})
      $display("FAIL op_replace_result: got %h/%h want B/0003", ALUOp, Display);
    else n_pass++;
  endtask

  task automatic test_chain();
    int bc;
    press(4'hF, 0, bc); press(4'h2, 0, bc); press(4'hA, 0, bc); press(4'h3, 0, bc);
    press(4'hA, 0, bc);
    n_checks++;
    if ({Display, ALUOp, ALUNum2} !== {16'h0005, 4'hA, 16'h0000})
      $display("FAIL chain_mid: got %h/%h/%h want 0005/A/0000", Display, ALUOp, ALUNum2);
    else n_pass++;
    press(4'h4, 0, bc); press(4'hE, 0, bc);
    n_checks++;
    if (Display !== 16'h0009) $display("FAIL chain_final: got %h want 0009", Display);
    else n_pass++;
    press(4'hE, 0, bc);
    n_checks++;
    if ({Display, ALUNum2} !== {16'h0013, 16'h0004})
      $display("FAIL repeat_equals: got %h/%h want 0013/0004", Display, ALUNum2);
    else n_pass++;
  endtask

  task automatic test_wait_drop();
    int bc;
    press(4'hF, 0, bc); press(4'h1, 0, bc); press(4'hA, 0, bc); press(4'h2, 0, bc);
    @(negedge CLK); KeyRead = 1'b1; BCDKey = 4'hE;
    @(negedge CLK); KeyRead = 1'b1; BCDKey = 4'h9;
    model_key(4'hE);
    n_checks++;
    if (Busy !== 1'b1) $display("FAIL wait_busy: got %b want 1", Busy);
    else n_pass++;
    @(negedge CLK); KeyRead = 1'b0;
    n_checks++;
    if ({ALUNum1, ALUNum2} !== {16'h0001, 16'h0002})
      $display("FAIL wait_drop_hold: got %h/%h want 0001/0002", ALUNum1, ALUNum2);
    else n_pass++;
    for (int i = 0; i < 40 && Busy === 1'b1; i++) @(negedge CLK);
    model_finish();
    n_checks++;
    if ({Display, ALUNum2, Busy} !== {16'h0003, 16'h0002, 1'b0})
      $display("FAIL wait_drop_result: got %h/%h/%b want 0003/0002/0", Display, ALUNum2, Busy);
    else n_pass++;
    // Asynchronous reset in the middle of an ALU run.
    press(4'hF, 0, bc); press(4'h3, 0, bc); press(4'hA, 0, bc); press(4'h4, 0, bc);
    @(negedge CLK); KeyRead = 1'b1; BCDKey = 4'hE;
    @(negedge CLK); KeyRead = 1'b0;
    #2 RESET = 1'b1;
    #1;
    n_checks++;
    if ({Display, ALUNum1, ALUNum2, ALUOp, Busy} !== {48'h0, 4'hA, 1'b0})
      $display("FAIL reset_mid_wait: got %h %h %h %h %b", Display, ALUNum1, ALUNum2, ALUOp, Busy);
    else n_pass++;
    @(negedge CLK); RESET = 1'b0;
    model_reset();
  endtask

  task automatic test_key_d();
    int bc;
`ifdef CALC_BACKSPACE_EN
    press(4'hF, 0, bc); press(4'h1, 0, bc); press(4'h2, 0, bc); press(4'h3, 0, bc);
    press(4'hD, 0, bc);
    n_checks++;
    if ({ALUNum1, Display} !== {16'h0012, 16'h0012})
      $display("FAIL backspace: got %h/%h want 0012/0012", ALUNum1, Display);
    else n_pass++;
    press(4'hF, 0, bc); press(4'hD, 0, bc);
    n_checks++;
    if ({ALUNum1, ALUOp} !== {16'h0000, 4'hA})
      $display("FAIL backspace_empty: got %h/%h want 0000/A", ALUNum1, ALUOp);
    else n_pass++;
`else
    press(4'hF, 0, bc); press(4'h1, 0, bc); press(4'hD, 0, bc);
    n_checks++;
    if ({ALUOp, Display} !== {4'hD, 16'h0001})
      $display("FAIL op_d: got %h/%h want D/0001", ALUOp, Display);
    else n_pass++;
`endif
  endtask

  task automatic test_random();
    int          bc, r;
    logic [3:0]  k;
    logic [52:0] exp;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55)      k = 4'($urandom_range(0, 9));
      else if (r < 75) k = 4'($urandom_range(10, 13));
      else if (r < 93) k = 4'hE;
      else             k = 4'hF;
      press(k, ($urandom_range(0, 2) == 0), bc);
      if (bc >= 0) begin
        n_checks++;
        if (bc !== int'(ALU_LAT + 1))
          $display("FAIL rand_busy_len[%0d]: got %0d want %0d", i, bc, ALU_LAT + 1);
        else n_pass++;
      end
      exp = {int2bcd(m_disp), int2bcd(m_n1), int2bcd(m_n2), m_op, 1'b0};
      n_checks++;
      if ({Display, ALUNum1, ALUNum2, ALUOp, Busy} !== exp)
        $display("FAIL rand_key[%0d] key %h: got %h %h %h %h %b want %h", i, k,
                 Display, ALUNum1, ALUNum2, ALUOp, Busy, exp);
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; KeyRead = 1'b0; BCDKey = 4'h0;
    model_reset();
    test_reset();
    test_basic();
    test_digit_limit();
    test_op_replace();
    test_chain();
    test_wait_drop();
    test_key_d();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
